// File: rtl/signed_mult_controller.sv
// Sequential controller for an 8x8 (WIDTH x WIDTH) signed multiplier.
// It latches the operands and hands them to an external sign/magnitude
// calculator. It then multiplies the magnitudes with a WIDTH-cycle
// shift-add loop and re-applies the sign. The result is a 2*WIDTH-bit
// two's-complement product, marked by a one-cycle done pulse.
module signed_mult_controller #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     num1,
   input  logic [WIDTH-1:0]     num2,
   output logic [WIDTH-1:0]     calc_num1,
   output logic [WIDTH-1:0]     calc_num2,
   input  logic [WIDTH-1:0]     calc_abs1,
   input  logic [WIDTH-1:0]     calc_abs2,
   input  logic                 calc_sign,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic                 sign_out
);

   localparam int PROD_W = 2 * WIDTH;
   localparam int CNT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      MULT = 2'd2,
      FIX  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    calc_num1_q, calc_num1_d;
   logic [WIDTH-1:0]    calc_num2_q, calc_num2_d;
   logic [PROD_W-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]    mplier_q, mplier_d;
   logic [PROD_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                sign_q, sign_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [PROD_W-1:0]   product_q, product_d;
   logic                sign_out_q, sign_out_d;

   logic                last_iter;

   assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

   // State and datapath registers, with a synchronous active-low reset that also abandons any operation in flight.
   // NOTE: sequential state uses non-blocking (<=) only, so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         calc_num1_q <= '0;
         calc_num2_q <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         sign_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         product_q   <= '0;
         sign_out_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         calc_num1_q <= calc_num1_d;
         calc_num2_q <= calc_num2_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sign_q      <= sign_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         product_q   <= product_d;
         sign_out_q  <= sign_out_d;
      end
   end

   // Next-state selection: IDLE -> LOAD -> MULT (WIDTH cycles) -> FIX -> IDLE.
   always_comb begin
      // NOTE: default assignment first; every path then assigns state_d, so no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = LOAD;
         LOAD:    state_d = MULT;
         MULT:    if (last_iter) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered-output next values for the current state; done is a pulse and defaults low.
   always_comb begin
      calc_num1_d = calc_num1_q;
      calc_num2_d = calc_num2_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      sign_d      = sign_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      product_d   = product_q;
      sign_out_d  = sign_out_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               calc_num1_d = num1;
               calc_num2_d = num2;
               busy_d      = 1'b1;
            end
         end
         LOAD: begin
            // Magnitudes are unsigned, so |-2^(WIDTH-1)| still fits in WIDTH bits.
            mcand_d  = {{WIDTH{1'b0}}, calc_abs1};
            mplier_d = calc_abs2;
            sign_d   = calc_sign;
            acc_d    = '0;
            cnt_d    = '0;
         end
         MULT: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
         end
         FIX: begin
            product_d  = sign_q ? ((~acc_q) + PROD_W'(1)) : acc_q;
            sign_out_d = sign_q & (acc_q != '0);
            done_d     = 1'b1;
            busy_d     = 1'b0;
         end
         default: ;
      endcase
   end

   assign calc_num1 = calc_num1_q;
   assign calc_num2 = calc_num2_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign product   = product_q;
   assign sign_out  = sign_out_q;

endmodule

// File: tb/tb_signed_mult_controller.sv
// Self-checking bench for signed_mult_controller. It models the external
// sign/magnitude calculator and keeps a queue of expected results. A
// negedge monitor pops and compares that queue on every done pulse.
module tb_signed_mult_controller;

   localparam int WIDTH = 8;
   localparam int PW    = 2 * WIDTH;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [WIDTH-1:0]  num1, num2;
   logic [WIDTH-1:0]  calc_num1, calc_num2;
   logic [WIDTH-1:0]  calc_abs1, calc_abs2;
   logic              calc_sign;
   logic              busy, done, sign_out;
   logic [PW-1:0]     product;

   typedef struct packed {
      logic [PW-1:0] prod;
      logic          sgn;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   done_count = 0;
   logic done_prev = 1'b0;

   signed_mult_controller #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .num1      (num1),
      .num2      (num2),
      .calc_num1 (calc_num1),
      .calc_num2 (calc_num2),
      .calc_abs1 (calc_abs1),
      .calc_abs2 (calc_abs2),
      .calc_sign (calc_sign),
      .busy      (busy),
      .done      (done),
      .product   (product),
      .sign_out  (sign_out)
   );

   always #5 clk = ~clk;

   // External sign/magnitude calculator.
   assign calc_abs1 = calc_num1[WIDTH-1] ? (WIDTH'(0) - calc_num1) : calc_num1;
   assign calc_abs2 = calc_num2[WIDTH-1] ? (WIDTH'(0) - calc_num2) : calc_num2;
   assign calc_sign = calc_num1[WIDTH-1] ^ calc_num2[WIDTH-1];

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic signed [PW-1:0] p;
      exp_t e;
      p = $signed(a) * $signed(b);
      e.prod = p;
      e.sgn  = (p < 0);
      return e;
   endfunction

   // Scoreboard monitor: every done pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         exp_t e;
         done_count++;
         checks++;
         if (done_prev === 1'b1) begin
            errors++;
            $display("FAIL done_width: done high on consecutive cycles, required single-cycle pulse");
         end
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: product=%h sign_out=%b with no pending operation", product, sign_out);
         end else begin
            e = sb.pop_front();
            if (product !== e.prod || sign_out !== e.sgn) begin
               errors++;
               $display("FAIL result: product=%h sign_out=%b, expected product=%h sign_out=%b",
                        product, sign_out, e.prod, e.sgn);
            end
         end
      end
      done_prev = done;
   end

   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      @(negedge clk);
      num1  = a;
      num2  = b;
      start = 1'b1;
      sb.push_back(model(a, b));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: %0d results still pending after %0d cycles, expected 0", name, sb.size(), n);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      num1  = '0;
      num2  = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || sign_out !== 1'b0 ||
          calc_num1 !== '0 || calc_num2 !== '0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b product=%h sign_out=%b calc=%h/%h, expected all zero",
                  busy, done, product, sign_out, calc_num1, calc_num2);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int busy_cnt = 0;
      int lat = -1;
      start_op(8'd7, 8'd6);
      checks++;
      if (calc_num1 !== 8'd7 || calc_num2 !== 8'd6) begin
         errors++;
         $display("FAIL basic_latch: calc=%h/%h, expected 07/06", calc_num1, calc_num2);
      end
      for (int i = 0; i < 30; i++) begin
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (busy_cnt != 10) begin
         errors++;
         $display("FAIL basic_busy_len: busy high %0d cycles, expected 10", busy_cnt);
      end
      checks++;
      if (lat != 10) begin
         errors++;
         $display("FAIL basic_latency: done after %0d cycles, expected 10", lat);
      end
      wait_done("basic");
   endtask

   task automatic test_signs();
      start_op(8'hF9, 8'd6);
      wait_done("neg_pos");
      start_op(8'hF9, 8'hFA);
      wait_done("neg_neg");
      start_op(8'd5, 8'hFD);
      wait_done("pos_neg");
   endtask

   task automatic test_corners();
      start_op(8'h80, 8'h80);
      wait_done("min_min");
      start_op(8'h80, 8'h7F);
      wait_done("min_max");
      start_op(8'h00, 8'hFF);
      wait_done("zero_neg");
      start_op(8'h7F, 8'h7F);
      wait_done("max_max");
   endtask

   task automatic test_ignore_start();
      int dc;
      dc = done_count;
      start_op(8'd12, 8'hFD);
      repeat (4) @(negedge clk);
      num1  = 8'h33;
      num2  = 8'h44;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (calc_num1 !== 8'd12 || calc_num2 !== 8'hFD) begin
         errors++;
         $display("FAIL ignore_latch: calc=%h/%h, expected 0c/fd", calc_num1, calc_num2);
      end
      wait_done("ignore");
      repeat (15) @(negedge clk);
      checks++;
      if (done_count != dc + 1) begin
         errors++;
         $display("FAIL ignore_done_count: %0d done pulses, expected 1", done_count - dc);
      end
   endtask

   task automatic test_reset_mid();
      int dc;
      start_op(8'h25, 8'h83);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      dc = done_count;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || sign_out !== 1'b0 || calc_num1 !== '0) begin
         errors++;
         $display("FAIL midreset_state: busy=%b done=%b product=%h sign_out=%b calc_num1=%h, expected all zero",
                  busy, done, product, sign_out, calc_num1);
      end
      repeat (15) @(negedge clk);
      checks++;
      if (done_count != dc) begin
         errors++;
         $display("FAIL midreset_no_done: %0d done pulses after reset, expected 0", done_count - dc);
      end
      start_op(8'h25, 8'h83);
      wait_done("after_reset");
   endtask

   task automatic test_back_to_back();
      int last = -1;
      int nd = 0;
      exp_t e;
      e = model(8'h9C, 8'h0B);
      repeat (3) sb.push_back(e);
      @(negedge clk);
      num1  = 8'h9C;
      num2  = 8'h0B;
      start = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (i == 29) start = 1'b0;
         if (done === 1'b1) begin
            if (nd > 0) begin
               checks++;
               if (i - last != 11) begin
                  errors++;
                  $display("FAIL b2b_interval: done spacing %0d cycles, expected 11", i - last);
               end
            end
            last = i;
            nd++;
         end
         if (nd > 0) begin
            checks++;
            if (product !== e.prod) begin
               errors++;
               $display("FAIL b2b_stable: product=%h, expected %h", product, e.prod);
            end
         end
      end
      checks++;
      if (nd != 3 || sb.size() != 0) begin
         errors++;
         $display("FAIL b2b_count: %0d done pulses, %0d pending, expected 3 and 0", nd, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] a, b;
      for (int i = 0; i < 12; i++) begin
         a = WIDTH'($urandom);
         b = WIDTH'($urandom);
         start_op(a, b);
         wait_done("random");
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_corners();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_random();
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
